ame_equation_builder: RTL and testbench

//  Initiator side of the affine-ME equation solver interface. Accepts a stream of per-pixel

---
 rtl/ame_equation_builder.sv | 166 ++++++++++++++++
 tb/tb_ame_equation_builder.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ame_equation_builder.sv
// Affine-ME equation builder: accumulates A=sum(g*g^T), B=sum(g*e) over a sample
// block, launches the solver, waits for completion and returns its parameters.
module ame_equation_builder #(
    parameter int unsigned COEF_BITS      = 16,
    parameter int unsigned COMP_DATA_BITS = 64,
    parameter int unsigned CNT_BITS       = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic                           start_i,
    input  logic                           affine_param6_i,
    output logic                           busy_o,
    input  logic                           samp_valid_i,
    output logic                           samp_ready_o,
    input  logic                           samp_last_i,
    input  logic [6*COEF_BITS-1:0]         samp_grad_i,
    input  logic [COEF_BITS-1:0]           samp_err_i,
    output logic                           solv_init_o,
    output logic                           solv_param6_o,
    output logic [6*7*COMP_DATA_BITS-1:0]  solv_data_o,
    input  logic                           solv_done_i,
    input  logic [6*COMP_DATA_BITS-1:0]    solv_data_i,
    output logic                           res_valid_o,
    input  logic                           res_ready_i,
    output logic [6*COMP_DATA_BITS-1:0]    res_data_o,
    output logic [CNT_BITS-1:0]            res_count_o
);

    localparam int unsigned NT = 6;
    localparam int unsigned NC = 7;
    localparam int unsigned PW = 2 * COEF_BITS;

    typedef enum logic [2:0] {
        S_IDLE, S_ACCUM, S_DRAIN0, S_DRAIN1, S_LAUNCH, S_WAIT, S_RESULT
    } state_t;

    state_t state;
    state_t state_nx;

    logic                        take;
    logic                        clr;
    logic                        p_vld;
    logic signed [COEF_BITS-1:0] gm [NT];
    logic signed [COEF_BITS-1:0] err;
    logic signed [PW-1:0]        prod_a [NT][NT];
    logic signed [PW-1:0]        prod_b [NT];
    logic [COMP_DATA_BITS-1:0]   acc_a  [NT][NT];
    logic [COMP_DATA_BITS-1:0]   acc_b  [NT];

    assign take = samp_valid_i & samp_ready_o;
    // Accumulators, counter and model select return to zero whenever IDLE is entered.
    assign clr  = (state_nx == S_IDLE);
    assign err  = samp_err_i;

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= S_IDLE;
        else          state <= state_nx;
    end

    // Next-state logic; DRAIN0/DRAIN1 cover the product and accumulate stages.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start_i) state_nx = S_ACCUM;
            S_ACCUM:  if (take && samp_last_i) state_nx = S_DRAIN0;
            S_DRAIN0: state_nx = S_DRAIN1;
            S_DRAIN1: state_nx = S_LAUNCH;
            S_LAUNCH: state_nx = S_WAIT;
            S_WAIT:   if (solv_done_i) state_nx = S_RESULT;
            S_RESULT: if (res_ready_i) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Registered status/handshake outputs decoded from the upcoming state.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            busy_o       <= 1'b0;
            samp_ready_o <= 1'b0;
            solv_init_o  <= 1'b0;
            res_valid_o  <= 1'b0;
        end else begin
            busy_o       <= (state_nx != S_IDLE);
            samp_ready_o <= (state_nx == S_ACCUM);
            solv_init_o  <= (state_nx == S_LAUNCH);
            res_valid_o  <= (state_nx == S_RESULT);
        end
    end

    // Model select latched on start, held until the block completes.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)                       solv_param6_o <= 1'b0;
        else if (state == S_IDLE && start_i) solv_param6_o <= affine_param6_i;
        else if (clr)                        solv_param6_o <= 1'b0;
    end

    // Gradient terms with g0/g1 forced to zero in the 4-parameter model.
    always_comb begin
        for (int k = 0; k < NT; k++) begin
            gm[k] = samp_grad_i[k*COEF_BITS +: COEF_BITS];
            if (!solv_param6_o && k < 2) gm[k] = '0;
        end
    end

    // Two-stage datapath: register upper-triangle products, then wrap-add into sums.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            p_vld <= 1'b0;
            for (int i = 0; i < NT; i++) begin
                prod_b[i] <= '0;
                acc_b[i]  <= '0;
                for (int j = i; j < NT; j++) begin
                    prod_a[i][j] <= '0;
                    acc_a[i][j]  <= '0;
                end
            end
        end else begin
            p_vld <= take;
            if (take) begin
                for (int i = 0; i < NT; i++) begin
                    prod_b[i] <= PW'(gm[i]) * PW'(err);
                    for (int j = i; j < NT; j++)
                        prod_a[i][j] <= PW'(gm[i]) * PW'(gm[j]);
                end
            end
            for (int i = 0; i < NT; i++) begin
                if (clr)        acc_b[i] <= '0;
                else if (p_vld) acc_b[i] <= acc_b[i] + COMP_DATA_BITS'(prod_b[i]);
                for (int j = i; j < NT; j++) begin
                    if (clr)        acc_a[i][j] <= '0;
                    else if (p_vld) acc_a[i][j] <= acc_a[i][j] + COMP_DATA_BITS'(prod_a[i][j]);
                end
            end
        end
    end

    // Saturating count of accepted samples.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)                         res_count_o <= '0;
        else if (clr)                         res_count_o <= '0;
        else if (take && (res_count_o != '1)) res_count_o <= res_count_o + CNT_BITS'(1);
    end

    // Capture solver results on its done pulse while waiting for it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)                          res_data_o <= '0;
        else if (state == S_WAIT && solv_done_i) res_data_o <= solv_data_i;
    end

    // Solver matrix view: A mirrored from the upper triangle, B in column 6.
    always_comb begin
        solv_data_o = '0;
        for (int i = 0; i < NT; i++) begin
            for (int j = 0; j < NC; j++) begin
                if (j == NT)
                    solv_data_o[(i*NC+j)*COMP_DATA_BITS +: COMP_DATA_BITS] = acc_b[i];
                else if (j >= i)
                    solv_data_o[(i*NC+j)*COMP_DATA_BITS +: COMP_DATA_BITS] = acc_a[i][j];
                else
                    solv_data_o[(i*NC+j)*COMP_DATA_BITS +: COMP_DATA_BITS] = acc_a[j][i];
            end
        end
    end

endmodule

// File: tb/tb_ame_equation_builder.sv
// Bench for ame_equation_builder: table of single-sample blocks, a long random block,
// disturbance and mid-block reset sequences; solver stub plus result scoreboard.
module tb_ame_equation_builder;

    localparam int unsigned CB  = 16;
    localparam int unsigned CDB = 64;
    localparam int unsigned CNT = 16;
    localparam int unsigned SDW = 6 * 7 * CDB;
    localparam int unsigned RDW = 6 * CDB;

    logic           clk_i = 1'b0;
    logic           rst_n_i;
    logic           start_i;
    logic           affine_param6_i;
    logic           busy_o;
    logic           samp_valid_i;
    logic           samp_ready_o;
    logic           samp_last_i;
    logic [6*CB-1:0] samp_grad_i;
    logic [CB-1:0]  samp_err_i;
    logic           solv_init_o;
    logic           solv_param6_o;
    logic [SDW-1:0] solv_data_o;
    logic           stub_done;
    logic           spur_done;
    logic [RDW-1:0] solv_data_i;
    logic           res_valid_o;
    logic           res_ready_i;
    logic [RDW-1:0] res_data_o;
    logic [CNT-1:0] res_count_o;

    ame_equation_builder #(.COEF_BITS(CB), .COMP_DATA_BITS(CDB), .CNT_BITS(CNT)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .affine_param6_i(affine_param6_i),
        .busy_o(busy_o), .samp_valid_i(samp_valid_i), .samp_ready_o(samp_ready_o),
        .samp_last_i(samp_last_i), .samp_grad_i(samp_grad_i), .samp_err_i(samp_err_i),
        .solv_init_o(solv_init_o), .solv_param6_o(solv_param6_o), .solv_data_o(solv_data_o),
        .solv_done_i(stub_done | spur_done), .solv_data_i(solv_data_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
        .res_count_o(res_count_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int inits  = 0;

    typedef struct packed {
        logic            p6;
        logic [5:0][15:0] g;
        logic [15:0]     e;
        int              ai;
        int              aj;
        logic [63:0]     ae;
        int              bi;
        logic [63:0]     be;
    } vec_t;

    vec_t tbl [8];
    int   sg [128][6];
    int   se [128];

    logic [SDW-1:0] mq [$];
    logic           pq [$];
    logic [RDW-1:0] rq [$];
    int             cq [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit p6, input int g0, input int g1, input int g2,
                                input int g3, input int g4, input int g5, input int e,
                                input int ai, input int aj, input longint ae,
                                input int bi, input longint be);
        vec_t v;
        v.p6 = p6;
        v.g  = {16'(g5), 16'(g4), 16'(g3), 16'(g2), 16'(g1), 16'(g0)};
        v.e  = 16'(e);
        v.ai = ai; v.aj = aj; v.ae = 64'(ae);
        v.bi = bi; v.be = 64'(be);
        return v;
    endfunction

    // Reference normal equations over the first n staged samples.
    function automatic logic [SDW-1:0] model(input bit p6, input int n);
        logic [SDW-1:0] m = '0;
        longint v;
        for (int s = 0; s < n; s++)
            for (int i = 0; i < 6; i++)
                for (int j = 0; j < 7; j++)
                    if ((p6 || i >= 2) && (j == 6 || p6 || j >= 2)) begin
                        v = (j == 6) ? longint'(sg[s][i]) * longint'(se[s])
                                     : longint'(sg[s][i]) * longint'(sg[s][j]);
                        m[(i*7+j)*CDB +: CDB] = m[(i*7+j)*CDB +: CDB] + 64'(v);
                    end
        return m;
    endfunction

    // Solver stub: checks the launched system, answers 37 cycles later.
    initial begin : stub
        logic [SDW-1:0] em;
        logic [RDW-1:0] x;
        int             blk = 0;
        stub_done   = 1'b0;
        solv_data_i = '0;
        forever begin
            @(negedge clk_i);
            if (solv_init_o) begin
                inits++;
                if (mq.size() == 0) begin
                    chk("unexpected_init", 64'(solv_init_o), 64'd0);
                end else begin
                    em = mq.pop_front();
                    chk("param6", 64'(solv_param6_o), 64'(pq.pop_front()));
                    for (int i = 0; i < 6; i++)
                        for (int j = 0; j < 7; j++)
                            chk($sformatf("M%0d%0d", i, j), solv_data_o[(i*7+j)*CDB +: CDB],
                                em[(i*7+j)*CDB +: CDB]);
                end
                repeat (36) @(negedge clk_i);
                for (int k = 0; k < 6; k++)
                    x[k*CDB +: CDB] = (64'(k + 1) << 8) | (64'(blk) << 32);
                solv_data_i = x;
                rq.push_back(x);
                stub_done = 1'b1;
                @(negedge clk_i);
                stub_done = 1'b0;
                blk++;
            end
        end
    end

    task automatic drive_sample(input int s, input bit last);
        samp_valid_i = 1'b1;
        samp_last_i  = last;
        for (int k = 0; k < 6; k++) samp_grad_i[k*CB +: CB] = 16'(sg[s][k]);
        samp_err_i = 16'(se[s]);
    endtask

    // Wait (bounded) for samp_ready_o with the current sample presented.
    task automatic wait_ready();
        int w = 0;
        while (!samp_ready_o && w < 50) begin @(negedge clk_i); w++; end
        if (w >= 50) chk("ready_timeout", 64'(samp_ready_o), 64'd1);
    endtask

    task automatic run_block(input bit p6, input int n, input bit gap, input int hold,
                             input bit disturb, input int tix);
        int lat;
        int w;
        int inits0;
        logic [RDW-1:0] xe;
        int ce;
        mq.push_back(model(p6, n));
        pq.push_back(p6);
        cq.push_back(n);
        inits0 = inits;
        @(negedge clk_i);
        start_i = 1'b1; affine_param6_i = p6;
        @(negedge clk_i);
        start_i = 1'b0; affine_param6_i = 1'b0;
        for (int s = 0; s < n; s++) begin
            if (gap) repeat ($urandom_range(0, 3)) @(negedge clk_i);
            drive_sample(s, s == n - 1);
            wait_ready();
            if (disturb && s == n / 2) begin start_i = 1'b1; spur_done = 1'b1; end
            @(negedge clk_i);
            start_i = 1'b0; spur_done = 1'b0;
            samp_valid_i = 1'b0; samp_last_i = 1'b0;
            if (disturb && s == n / 2) begin
                chk("accum_hold_ready", 64'(samp_ready_o), 64'd1);
                chk("accum_hold_valid", 64'(res_valid_o), 64'd0);
            end
        end
        lat = 1;
        while (!solv_init_o && lat < 10) begin @(negedge clk_i); lat++; end
        chk("init_latency", 64'(lat), 64'd3);
        if (tix >= 0) begin
            chk($sformatf("tbl%0d_A%0d%0d", tix, tbl[tix].ai, tbl[tix].aj),
                solv_data_o[(tbl[tix].ai*7+tbl[tix].aj)*CDB +: CDB], tbl[tix].ae);
            chk($sformatf("tbl%0d_B%0d", tix, tbl[tix].bi),
                solv_data_o[(tbl[tix].bi*7+6)*CDB +: CDB], tbl[tix].be);
        end
        @(negedge clk_i);
        chk("init_one_cycle", 64'(solv_init_o), 64'd0);
        if (disturb) begin
            start_i = 1'b1;
            @(negedge clk_i);
            start_i = 1'b0;
            chk("wait_hold_busy", 64'(busy_o), 64'd1);
            chk("wait_hold_valid", 64'(res_valid_o), 64'd0);
        end
        w = 0;
        while (!res_valid_o && w < 200) begin @(negedge clk_i); w++; end
        chk("res_valid", 64'(res_valid_o), 64'd1);
        if (rq.size() > 0) begin
            xe = rq.pop_front();
            ce = cq.pop_front();
            chk("res_count", 64'(res_count_o), 64'(ce));
            for (int k = 0; k < 6; k++)
                chk($sformatf("res_X%0d", k), res_data_o[k*CDB +: CDB], xe[k*CDB +: CDB]);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk_i);
                chk("hold_valid", 64'(res_valid_o), 64'd1);
                chk("hold_X0", res_data_o[0 +: CDB], xe[0 +: CDB]);
                chk("hold_X5", res_data_o[5*CDB +: CDB], xe[5*CDB +: CDB]);
                chk("hold_count", 64'(res_count_o), 64'(ce));
            end
        end
        res_ready_i = 1'b1;
        @(negedge clk_i);
        res_ready_i = 1'b0;
        chk("idle_busy", 64'(busy_o), 64'd0);
        chk("idle_valid", 64'(res_valid_o), 64'd0);
        chk("idle_solv_data_zero", 64'(solv_data_o != '0), 64'd0);
        chk("idle_param6", 64'(solv_param6_o), 64'd0);
        chk("init_pulses", 64'(inits - inits0), 64'd1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin : main
        rst_n_i = 1'b0; start_i = 1'b0; affine_param6_i = 1'b0;
        samp_valid_i = 1'b0; samp_last_i = 1'b0; samp_grad_i = '0; samp_err_i = '0;
        res_ready_i = 1'b0; spur_done = 1'b0;

        tbl[0] = mk(0, 9, 9, 1, 2, 3, 4, 5,  2, 3, 2,  5, 20);
        tbl[1] = mk(0, 9, 9, 1, 2, 3, 4, 5,  2, 5, 4,  0, 0);
        tbl[2] = mk(0, 9, 9, 1, 2, 3, 4, 5,  5, 5, 16, 2, 5);
        tbl[3] = mk(0, 9, 9, 1, 2, 3, 4, 5,  1, 3, 0,  1, 0);
        tbl[4] = mk(1, -3, 0, 0, 0, 0, 0, 7, 0, 0, 9,  0, -21);
        tbl[5] = mk(1, -32768, 32767, 0, 0, 0, 0, -32768, 0, 1, -1073709056, 0, 1073741824);
        tbl[6] = mk(1, 5, 5, -1, 0, 0, -7, 3, 5, 0, -35, 5, -21);
        tbl[7] = mk(0, 5, 5, -1, 0, 0, -7, 3, 5, 2, 7,   5, -21);

        repeat (3) @(negedge clk_i);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_ready", 64'(samp_ready_o), 64'd0);
        chk("rst_init", 64'(solv_init_o), 64'd0);
        chk("rst_valid", 64'(res_valid_o), 64'd0);
        chk("rst_count", 64'(res_count_o), 64'd0);
        chk("rst_solv_data_zero", 64'(solv_data_o != '0), 64'd0);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        for (int t = 0; t < 8; t++) begin
            for (int k = 0; k < 6; k++) sg[0][k] = int'($signed(tbl[t].g[k]));
            se[0] = int'($signed(tbl[t].e));
            run_block(tbl[t].p6, 1, 1'b0, 0, 1'b0, t);
        end

        for (int s = 0; s < 100; s++) begin
            for (int k = 0; k < 6; k++) sg[s][k] = int'($urandom_range(0, 65535)) - 32768;
            se[s] = int'($urandom_range(0, 65535)) - 32768;
        end
        run_block(1'b1, 100, 1'b1, 10, 1'b0, -1);

        for (int s = 0; s < 8; s++) begin
            for (int k = 0; k < 6; k++) sg[s][k] = int'($urandom_range(0, 200)) - 100;
            se[s] = int'($urandom_range(0, 200)) - 100;
        end
        run_block(1'b0, 8, 1'b1, 2, 1'b1, -1);

        // Reset in ACCUM after five samples, then a one-sample restart.
        @(negedge clk_i);
        start_i = 1'b1; affine_param6_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0; affine_param6_i = 1'b0;
        for (int s = 0; s < 5; s++) begin
            drive_sample(s, 1'b0);
            wait_ready();
            @(negedge clk_i);
            samp_valid_i = 1'b0;
        end
        chk("pre_rst_count", 64'(res_count_o), 64'd5);
        rst_n_i = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy_o), 64'd0);
        chk("midrst_ready", 64'(samp_ready_o), 64'd0);
        chk("midrst_count", 64'(res_count_o), 64'd0);
        chk("midrst_param6", 64'(solv_param6_o), 64'd0);
        chk("midrst_solv_data_zero", 64'(solv_data_o != '0), 64'd0);
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (4) @(negedge clk_i);
        chk("midrst_no_init", 64'(inits), 64'd10);
        sg[0] = '{7, -2, 3, 0, 11, -5};
        se[0] = -9;
        run_block(1'b1, 1, 1'b0, 0, 1'b0, -1);

        chk("queues_drained", 64'(mq.size() + rq.size() + cq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
